cmd_input_conditioner: RTL
==========================

Name: cmd_input_conditioner

Overview:
- Upstream stage of the control FSM. It takes a raw, asynchronous 3-bit user command, synchronises and debounces it, and screens it against a legal-code mask.
- Each accepted change is presented as a registered 3-bit command (cmd_out, driven into the FSM's user_input) with a one-cycle cmd_valid strobe.
- Illegal codes are reported on cmd_err and never reach cmd_out, so the downstream FSM only sees settled, legal commands.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised input must hold the same value before acceptance (legal range 1..15).
- HOLDOFF_CYCLES, 2, dead cycles after each accept or reject (legal range 1..15).
- LEGAL_MASK, 8'h1F, bit n set means code n is legal.
- ERR_CNT_W, 8, width of the optional error counter.

Ports:
- clk  in  1  single clock; all flops rise-edge.
- rst_n  in  1  asynchronous, active-low reset.
- raw_in  in  3  asynchronous raw command.
- cmd_out  out  3  last accepted legal command, registered.
- cmd_valid  out  1  one-cycle pulse when cmd_out is updated.
- cmd_err  out  1  one-cycle pulse when an illegal settled code is rejected.
- err_count  out  ERR_CNT_W  present only with CMD_ERR_COUNT_EN.

Behaviour:
- Reset (async assert, sync release):
  - sync flops, cand, last_code, cnt and cmd_out go to 0.
  - cmd_valid and cmd_err go to 0; state goes to IDLE.
  - Reset mid-operation aborts any pending command; nothing is emitted for it.
- Synchroniser: two flops on raw_in; sync_q is the second stage.
- FSM, 2-bit encoding:
  - IDLE (00):
    - If sync_q != last_code: cand <= sync_q, cnt <= 0, go to SETTLE.
    - Else stay.
  - SETTLE (01):
    - If sync_q == last_code: go to IDLE (reverted glitch, no output).
    - Else if sync_q != cand: cand <= sync_q, cnt <= 0 (restart).
    - Else if cnt == DEBOUNCE_CYCLES-1: go to EMIT.
    - Else cnt++.
  - EMIT (10), lasts exactly one cycle:
    - last_code <= cand in all cases.
    - If LEGAL_MASK[cand]: cmd_out <= cand, cmd_valid <= 1 next cycle.
    - Else: cmd_err <= 1 next cycle; cmd_out unchanged.
    - cnt <= 0, go to HOLDOFF.
  - HOLDOFF (11):
    - Input is ignored.
    - When cnt == HOLDOFF_CYCLES-1, go to IDLE; else cnt++.
  - Default branch (unreachable encodings or corruption): go to IDLE with cnt <= 0. Outputs are not touched.
- Latency: raw_in stable from sampling edge 1 gives cmd_valid high after edge DEBOUNCE_CYCLES+4 (8 with defaults). cmd_out changes on that same edge.
- cmd_valid and cmd_err are mutually exclusive and never high for two consecutive cycles.
- A held illegal code is reported once only, because last_code records it.
- Changes during HOLDOFF are seen in IDLE via comparison with last_code; no event is lost if the input stays stable.
- cmd_out holds its value indefinitely between accepts.
- Code 0 is the post-reset last_code. A raw value of 0 after reset therefore produces no event.

Optional Feature:
- Macro: CMD_ERR_COUNT_EN.
- Defined:
  - err_count port exists; reset value 0.
  - Increments on each cmd_err pulse and saturates at all-ones (no wrap).
- Undefined:
  - Port and counter are absent; cmd_err behaviour is identical.

Decomposition:
- Package cmd_cond_pkg:
  - CMD_W = 3.
  - State typedef cmd_state_t with IDLE/SETTLE/EMIT/HOLDOFF encodings 2'b00/01/10/11.
  - Default LEGAL_MASK constant.
- Sub-module cmd_sync2: parameterised-width 2-flop synchroniser with async active-low reset to 0.
- FSM, counter and output registers live in the top module.

Test Plan:
1. Reset, then raw_in=3'h2 held → cmd_valid single pulse after edge 8, cmd_out=2, cmd_err stays 0.
2. raw_in=3'h5 for 3 cycles, then back to 3'h0 (DEBOUNCE_CYCLES=4) → no cmd_valid, no cmd_err, FSM returns to IDLE, cmd_out=0.
3. raw_in=3'h6 held 50 cycles (LEGAL_MASK=8'h1F) → exactly one cmd_err pulse, cmd_out unchanged; then raw_in=3'h1 → one cmd_valid with cmd_out=1.
4. raw_in=3'h2 accepted, then raw_in=3'h3 applied during HOLDOFF → 3 emitted after holdoff plus debounce; no lost or duplicated strobe.
5. rst_n low mid-SETTLE with raw_in=3'h4 → outputs 0 immediately. After release with raw_in still 4, a fresh full debounce runs, then exactly one cmd_valid.
6. With CMD_ERR_COUNT_EN defined, 300 alternating illegal codes 6/7 → err_count saturates at 255; without the macro the bench compiles with no err_count port.

Source files
------------

// File: rtl/cmd_cond_pkg.sv
// rtl/cmd_cond_pkg.sv - shared widths, FSM encoding and default legal-code mask
package cmd_cond_pkg;

    localparam int CMD_W = 3;

    localparam logic [7:0] DEFAULT_LEGAL_MASK = 8'h1F;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETTLE  = 2'b01,
        EMIT    = 2'b10,
        HOLDOFF = 2'b11
    } cmd_state_t;

endpackage

// File: rtl/cmd_input_conditioner_if.sv
// rtl/cmd_input_conditioner_if.sv - raw command in / conditioned command out bundle; err_count with CMD_ERR_COUNT_EN
interface cmd_input_conditioner_if
`ifdef CMD_ERR_COUNT_EN
    #(parameter int ERR_CNT_W = 8)
`endif
    ;
    import cmd_cond_pkg::*;

    logic [CMD_W-1:0] raw_in;
    logic [CMD_W-1:0] cmd_out;
    logic             cmd_valid;
    logic             cmd_err;
`ifdef CMD_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_count;

    modport master (output raw_in, input cmd_out, input cmd_valid, input cmd_err, input err_count);
    modport slave  (input raw_in, output cmd_out, output cmd_valid, output cmd_err, output err_count);
`else
    modport master (output raw_in, input cmd_out, input cmd_valid, input cmd_err);
    modport slave  (input raw_in, output cmd_out, output cmd_valid, output cmd_err);
`endif

endinterface

// File: rtl/cmd_input_conditioner_sync2.sv
// rtl/cmd_input_conditioner_sync2.sv - two-flop synchroniser, async active-low reset to 0
module cmd_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/cmd_input_conditioner.sv
// rtl/cmd_input_conditioner.sv - sync, debounce and legal-mask screen of a raw command; CMD_ERR_COUNT_EN adds err_count
module cmd_input_conditioner
    import cmd_cond_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         HOLDOFF_CYCLES  = 2,
    parameter logic [7:0] LEGAL_MASK      = DEFAULT_LEGAL_MASK
`ifdef CMD_ERR_COUNT_EN
    ,
    parameter int         ERR_CNT_W       = 8
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cmd_input_conditioner_if.slave bus
);

    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF_CYCLES - 1);

    logic [CMD_W-1:0] w_sync_q;

    cmd_state_t       r_state,     w_state_nxt;
    logic [CMD_W-1:0] r_cand,      w_cand_nxt;
    logic [CMD_W-1:0] r_last_code, w_last_nxt;
    logic [CMD_W-1:0] r_cmd_out,   w_cmd_out_nxt;
    logic [3:0]       r_cnt,       w_cnt_nxt;
    logic             r_cmd_valid, w_valid_nxt;
    logic             r_cmd_err,   w_err_nxt;

    cmd_sync2 #(.WIDTH(CMD_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.raw_in),
        .o_q   (w_sync_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cand      <= '0;
            r_last_code <= '0;
            r_cmd_out   <= '0;
            r_cnt       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_last_code <= w_last_nxt;
            r_cmd_out   <= w_cmd_out_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_valid <= w_valid_nxt;
            r_cmd_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cand_nxt    = r_cand;
        w_last_nxt    = r_last_code;
        w_cmd_out_nxt = r_cmd_out;
        w_cnt_nxt     = r_cnt;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sync_q != r_last_code) begin
                    w_cand_nxt  = w_sync_q;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // Returning to the last reported code is a glitch, not a new command.
                if (w_sync_q == r_last_code) begin
                    w_state_nxt = IDLE;
                end else if (w_sync_q != r_cand) begin
                    w_cand_nxt = w_sync_q;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = EMIT;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            EMIT: begin
                // Illegal codes are recorded too, so a held bad code reports once.
                w_last_nxt = r_cand;
                if (LEGAL_MASK[r_cand]) begin
                    w_cmd_out_nxt = r_cand;
                    w_valid_nxt   = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                end
                w_cnt_nxt   = '0;
                w_state_nxt = HOLDOFF;
            end
            HOLDOFF: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.cmd_out   = r_cmd_out;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_err   = r_cmd_err;

`ifdef CMD_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    // Counts alongside the cmd_err register so the count and the pulse appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_err_nxt && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.err_count = r_err_count;
`endif

endmodule
